cond_branch_unit: RTL and testbench

- Condition register and conditional-GOTO evaluator for the relay ALU.
- Consumes the ALU flags (zero from the zero-detect chain, carry, sign) and latches them on a load strobe.
- Answers branch requests from the sequencer through a req/ack handshake, after a programmable relay-settle delay.
- When the branch is taken, drives the PC load and target.

---
 rtl/cond_branch_unit_if.sv | 15 +
 rtl/cond_branch_unit.sv | 69 ++++++
 tb/tb_cond_branch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cond_branch_unit_if.sv
// cond_branch_unit_if: branch request/response bundle between the sequencer and the condition unit
interface cond_branch_unit_if #(parameter int ADDR_W = 16);
  logic              branch_req;
  logic [3:0]        cond;
  logic [ADDR_W-1:0] target;
  logic              busy;
  logic              branch_ack;
  logic              branch_taken;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  modport master (output branch_req, cond, target,
                  input  busy, branch_ack, branch_taken, pc_load, pc_target);
  modport slave  (input  branch_req, cond, target,
                  output busy, branch_ack, branch_taken, pc_load, pc_target);
endinterface

// File: rtl/cond_branch_unit.sv
// cond_branch_unit: ALU condition register and conditional-GOTO evaluator with relay settle delay
module cond_branch_unit #(
  parameter int SETTLE_CYCLES = 3,
  parameter int ADDR_W        = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flags_load,
  input  logic zero_in,
  input  logic carry_in,
  input  logic sign_in,
  output logic flag_z,
  output logic flag_c,
  output logic flag_s,
  cond_branch_unit_if.slave br
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic [3:0]        cond_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              ez, ec, es;
  logic              taken;
  // mask bits {S,C,Z,NZ}; an empty mask is an unconditional jump
  assign taken   = (cond_q == 4'd0) | (cond_q[3] & es) | (cond_q[2] & ec) |
                   (cond_q[1] & ez) | (cond_q[0] & ~ez);
  assign br.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      cond_q          <= 4'd0;
      tgt_q           <= '0;
      {ez, ec, es}    <= 3'b000;
      {flag_z, flag_c, flag_s} <= 3'b000;
      br.branch_ack   <= 1'b0;
      br.branch_taken <= 1'b0;
      br.pc_load      <= 1'b0;
      br.pc_target    <= '0;
    end else begin
      if (flags_load) {flag_z, flag_c, flag_s} <= {zero_in, carry_in, sign_in};
      br.branch_ack   <= 1'b0;
      br.branch_taken <= 1'b0;
      br.pc_load      <= 1'b0;
      case (state)
        IDLE: if (br.branch_req) begin
          // a flag load on the acceptance edge is already visible to this branch
          {ez, ec, es} <= flags_load ? {zero_in, carry_in, sign_in} : {flag_z, flag_c, flag_s};
          cond_q       <= br.cond;
          tgt_q        <= br.target;
          cnt          <= 4'(SETTLE_CYCLES);
          state        <= (SETTLE_CYCLES > 0) ? SETTLE : RESP;
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          br.branch_ack   <= 1'b1;
          br.branch_taken <= taken;
          br.pc_load      <= taken;
          if (taken) br.pc_target <= tgt_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: directed and randomized checks of two units (settle 3 and settle 0) against a flag/condition model
module tb_cond_branch_unit;
  logic        clk = 1'b0;
  logic        reset_n, flags_load, zero_in, carry_in, sign_in;
  logic [1:0]  req;
  logic [3:0]  cond;
  logic [15:0] target;
  logic [1:0]  fz, fc, fs, ack, tkn, pcl, bsy;
  logic [15:0] pct [2];
  logic [2:0]  mf;
  logic [15:0] exp_pc [2];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  cond_branch_unit_if #(.ADDR_W(16)) i3 ();
  cond_branch_unit_if #(.ADDR_W(16)) i0 ();

  assign i3.branch_req = req[0];
  assign i3.cond       = cond;
  assign i3.target     = target;
  assign i0.branch_req = req[1];
  assign i0.cond       = cond;
  assign i0.target     = target;
  assign ack = {i0.branch_ack, i3.branch_ack};
  assign tkn = {i0.branch_taken, i3.branch_taken};
  assign pcl = {i0.pc_load, i3.pc_load};
  assign bsy = {i0.busy, i3.busy};
  assign pct[0] = i3.pc_target;
  assign pct[1] = i0.pc_target;

  cond_branch_unit #(.SETTLE_CYCLES(3), .ADDR_W(16)) u3 (
    .clk(clk), .reset_n(reset_n), .flags_load(flags_load), .zero_in(zero_in),
    .carry_in(carry_in), .sign_in(sign_in), .flag_z(fz[0]), .flag_c(fc[0]),
    .flag_s(fs[0]), .br(i3));
  cond_branch_unit #(.SETTLE_CYCLES(0), .ADDR_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .flags_load(flags_load), .zero_in(zero_in),
    .carry_in(carry_in), .sign_in(sign_in), .flag_z(fz[1]), .flag_c(fc[1]),
    .flag_s(fs[1]), .br(i0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags as {s,c,z}; a branch is taken when the mask is empty or any selected condition holds
  function automatic bit model_taken(input logic [3:0] c, input logic [2:0] f);
    logic [3:0] status;
    status = {f[2], f[1], f[0], ~f[0]};
    return (c == 4'd0) || ((c & status) != 4'd0);
  endfunction

  task automatic chk_flags(input string tag);
    for (int d = 0; d < 2; d++)
      chk(tag, {29'd0, fs[d], fc[d], fz[d]}, {29'd0, mf});
  endtask

  task automatic load_flags(input logic [2:0] f);
    @(negedge clk);
    flags_load = 1'b1;
    {sign_in, carry_in, zero_in} = f;
    @(negedge clk);
    flags_load = 1'b0;
    mf = f;
    chk_flags("flags_load");
  endtask

  task automatic branch(input int d, input logic [3:0] c, input logic [15:0] t,
                        input bit acc_load, input int pulse_n, input logic [2:0] nf);
    logic [2:0] snap;
    bit         tk;
    bit         got;
    int         n;
    @(negedge clk);
    req[d] = 1'b1;
    cond   = c;
    target = t;
    if (acc_load) begin
      flags_load = 1'b1;
      {sign_in, carry_in, zero_in} = nf;
      mf = nf;
    end
    snap = mf;
    tk   = model_taken(c, snap);
    if (tk) exp_pc[d] = t;
    n   = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      flags_load = 1'b0;
      if (n == pulse_n) begin
        flags_load = 1'b1;
        {sign_in, carry_in, zero_in} = nf;
        mf = nf;
      end
      if (ack[d]) got = 1;
    end
    req[d]     = 1'b0;
    flags_load = 1'b0;
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("latency", n, (d == 0) ? 32'd5 : 32'd2);
    chk("taken", {31'd0, tkn[d]}, {31'd0, tk});
    chk("pc_load", {31'd0, pcl[d]}, {31'd0, tk});
    chk("pc_target", {16'd0, pct[d]}, {16'd0, exp_pc[d]});
    @(negedge clk);
    chk("ack_pulse", {29'd0, ack[d], tkn[d], pcl[d]}, 32'd0);
    chk("pc_hold", {16'd0, pct[d]}, {16'd0, exp_pc[d]});
    chk_flags("flags_after");
  endtask

  initial begin
    int n;
    reset_n = 1'b0; flags_load = 1'b0; zero_in = 1'b0; carry_in = 1'b0; sign_in = 1'b0;
    req = 2'b11; cond = 4'd0; target = 16'h0;
    mf = 3'b000; exp_pc[0] = 16'h0; exp_pc[1] = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {ack, tkn, pcl, bsy}, 32'd0);
    chk("rst_pc", {pct[0], pct[1]}, 32'd0);
    chk_flags("rst_flags");
    reset_n = 1'b1;
    req     = 2'b00;
    @(negedge clk);
    chk("rst_no_accept", {30'd0, bsy}, 32'd0);

    load_flags(3'b001);
    branch(0, 4'b0010, 16'h1234, 0, 0, 3'b000);
    branch(0, 4'b0001, 16'h5555, 0, 0, 3'b000);
    load_flags(3'b000);
    branch(0, 4'b0000, 16'h00FF, 0, 0, 3'b000);
    branch(0, 4'b0010, 16'h2222, 0, 1, 3'b001);
    load_flags(3'b000);
    branch(0, 4'b0010, 16'h3333, 1, 0, 3'b001);
    branch(1, 4'b1000, 16'hBEEF, 0, 0, 3'b000);
    branch(1, 4'b0010, 16'hCAFE, 0, 0, 3'b000);

    // settle-0 unit with request held through the ack: next ack two cycles later
    @(negedge clk);
    req[1] = 1'b1; cond = 4'b0000; target = 16'h0A0A;
    exp_pc[1] = 16'h0A0A;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack[1] && n < 40);
    chk("b2b_first", n, 32'd2);
    target = 16'h0B0B;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack[1] && n < 40);
    chk("b2b_second", n, 32'd2);
    exp_pc[1] = 16'h0B0B;
    chk("b2b_pc", {16'd0, pct[1]}, {16'd0, exp_pc[1]});
    req[1] = 1'b0;
    @(negedge clk);
    chk("b2b_end", {31'd0, ack[1]}, 32'd0);

    // reset in the middle of settling abandons the branch
    @(negedge clk);
    req[0] = 1'b1; cond = 4'b0000; target = 16'h7777;
    @(negedge clk);
    chk("settle_busy", {31'd0, bsy[0]}, 32'd1);
    reset_n = 1'b0;
    req[0]  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mf = 3'b000; exp_pc[0] = 16'h0; exp_pc[1] = 16'h0;
    chk("abort_busy", {30'd0, bsy}, 32'd0);
    n = 0;
    repeat (6) begin @(negedge clk); if (ack[0]) n++; end
    chk("abort_no_ack", n, 32'd0);
    chk("abort_pc", {16'd0, pct[0]}, 32'd0);
    chk_flags("abort_flags");

    for (int i = 0; i < 24; i++) begin
      int         d;
      logic [3:0] c;
      logic [2:0] nf;
      bit         acc;
      int         pn;
      d   = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) load_flags(3'($urandom));
      c   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      nf  = 3'($urandom);
      acc = $urandom_range(0, 3) == 0;
      pn  = (!acc && d == 0) ? int'($urandom_range(0, 3)) : 0;
      branch(d, c, 16'($urandom), acc, pn, nf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
